// File: rtl/race_controller_if.sv
`default_nettype none
// ============================================================================
// Module  : race_controller_if
// Brief   : Player-side handshake and light/arbiter outputs of the race controller.
// Revision: 1.0
// ============================================================================
interface race_controller_if #(
  parameter int N_PLAYERS = 4
);
  localparam int PW = $clog2(N_PLAYERS);
  localparam int RW = $clog2(N_PLAYERS + 1);

  logic                 start;
  logic [N_PLAYERS-1:0] player_finish;
  logic [N_PLAYERS-1:0] player_out;
  logic                 enable;
  logic                 red;
  logic [2:0]           state;
  logic [7:0]           countdown;
  logic                 place_valid;
  logic [PW-1:0]        place_player;
  logic [RW-1:0]        place_rank;
  logic                 done;

  modport master (
    input  start, player_finish, player_out,
    output enable, red, state, countdown, place_valid, place_player, place_rank, done
  );

  modport slave (
    output start, player_finish, player_out,
    input  enable, red, state, countdown, place_valid, place_player, place_rank, done
  );
endinterface
`default_nettype wire

// File: rtl/race_controller.sv
`default_nettype none
// ============================================================================
// Module  : race_controller
// Brief   : Click-race sequencer: red/green light, random green timing, finish arbiter.
// Revision: 1.0
// ============================================================================
module race_controller #(
  parameter int         N_PLAYERS       = 4,
  parameter int         COUNTDOWN       = 4,
  parameter int         GREEN_MIN       = 8,
  parameter int         GREEN_RAND_BITS = 3,
  parameter int         RED_CYCLES      = 6,
  parameter logic [7:0] LFSR_SEED       = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  race_controller_if.master bus
);
  localparam int                   PW             = $clog2(N_PLAYERS);
  localparam int                   RW             = $clog2(N_PLAYERS + 1);
  localparam logic [7:0]           RAND_MASK      = 8'((1 << GREEN_RAND_BITS) - 1);
  localparam logic [7:0]           COUNTDOWN_LOAD = 8'(COUNTDOWN - 1);
  localparam logic [7:0]           GREEN_BASE     = 8'(GREEN_MIN - 1);
  localparam logic [7:0]           RED_LOAD       = 8'(RED_CYCLES - 1);
  localparam logic [N_PLAYERS-1:0] ALL_PLAYERS    = '1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_COUNTDOWN = 3'd1,
    S_GREEN     = 3'd2,
    S_RED       = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  state_t               r_state, w_state_next;
  logic [7:0]           r_timer, w_timer_next;
  logic [7:0]           r_lfsr;
  logic [N_PLAYERS-1:0] r_finished, w_finished_next;
  logic [N_PLAYERS-1:0] r_out, w_out_next;
  logic [RW-1:0]        r_next_rank, w_next_rank_next;
  logic                 r_place_valid, w_place_valid_next;
  logic [PW-1:0]        r_place_player, w_place_player_next;
  logic [RW-1:0]        r_place_rank, w_place_rank_next;
  logic                 r_enable, r_red, r_done;

  logic                 w_lfsr_fb;
  logic [7:0]           w_green_load;
  logic                 w_playing;
  logic [N_PLAYERS-1:0] w_cand;
  logic [PW-1:0]        w_pick;

  // Taps 8,6,5,4 of the polynomial map to register bits 7,5,4,3.
  assign w_lfsr_fb    = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
  assign w_green_load = GREEN_BASE + (r_lfsr & RAND_MASK);
  assign w_playing    = (r_state == S_GREEN) || (r_state == S_RED);
  assign w_cand       = bus.player_finish & ~r_finished & ~r_out;

  // Descending scan so the lowest candidate index wins.
  always_comb begin : pick_lowest
    w_pick = '0;
    for (int i = N_PLAYERS - 1; i >= 0; i--) begin
      if (w_cand[i]) w_pick = PW'(i);
    end
  end

  always_comb begin : next_state
    w_state_next        = r_state;
    w_timer_next        = r_timer;
    w_finished_next     = r_finished;
    w_out_next          = r_out;
    w_next_rank_next    = r_next_rank;
    w_place_valid_next  = 1'b0;
    w_place_player_next = r_place_player;
    w_place_rank_next   = r_place_rank;

    case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          w_state_next     = S_COUNTDOWN;
          w_timer_next     = COUNTDOWN_LOAD;
          w_finished_next  = '0;
          w_out_next       = '0;
          w_next_rank_next = RW'(1);
        end
      end
      S_COUNTDOWN: begin
        if (r_timer == 8'd0) begin
          w_state_next = S_GREEN;
          w_timer_next = w_green_load;
        end else begin
          w_timer_next = r_timer - 8'd1;
        end
      end
      S_GREEN: begin
        if (r_timer == 8'd0) begin
          w_state_next = S_RED;
          w_timer_next = RED_LOAD;
        end else begin
          w_timer_next = r_timer - 8'd1;
        end
      end
      S_RED: begin
        if (r_timer == 8'd0) begin
          w_state_next = S_GREEN;
          w_timer_next = w_green_load;
        end else begin
          w_timer_next = r_timer - 8'd1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_timer_next = 8'd0;
      end
    endcase

    if (w_playing) begin
      w_out_next = r_out | (bus.player_out & ~r_finished);
      if (|w_cand) begin
        w_place_valid_next      = 1'b1;
        w_place_player_next     = w_pick;
        w_place_rank_next       = r_next_rank;
        w_finished_next[w_pick] = 1'b1;
        w_next_rank_next        = r_next_rank + RW'(1);
      end
      // Game end takes priority over the phase timer.
      if ((w_finished_next | w_out_next) == ALL_PLAYERS) begin
        w_state_next = S_DONE;
        w_timer_next = 8'd0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin : regs
    if (rst) begin
      r_state        <= S_IDLE;
      r_timer        <= 8'd0;
      r_lfsr         <= LFSR_SEED;
      r_finished     <= '0;
      r_out          <= '0;
      r_next_rank    <= RW'(1);
      r_place_valid  <= 1'b0;
      r_place_player <= '0;
      r_place_rank   <= '0;
      r_enable       <= 1'b0;
      r_red          <= 1'b1;
      r_done         <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_timer        <= w_timer_next;
      r_lfsr         <= {r_lfsr[6:0], w_lfsr_fb};
      r_finished     <= w_finished_next;
      r_out          <= w_out_next;
      r_next_rank    <= w_next_rank_next;
      r_place_valid  <= w_place_valid_next;
      r_place_player <= w_place_player_next;
      r_place_rank   <= w_place_rank_next;
      r_enable       <= (w_state_next == S_GREEN) || (w_state_next == S_RED);
      r_red          <= (w_state_next != S_GREEN);
      r_done         <= (w_state_next == S_DONE);
    end
  end

  assign bus.state        = r_state;
  assign bus.countdown    = r_timer;
  assign bus.enable       = r_enable;
  assign bus.red          = r_red;
  assign bus.done         = r_done;
  assign bus.place_valid  = r_place_valid;
  assign bus.place_player = r_place_player;
  assign bus.place_rank   = r_place_rank;
endmodule
`default_nettype wire

// File: doc/race_controller.md
Name: race_controller

Overview:
- Central sequencer for the click-race game.
- Drives the shared red/green light and the per-player `enable` to every player's game logic instance.
- Generates pseudo-random green-phase durations.
- Acts as the finish arbiter: serialises simultaneous finishers into unique places (1st, 2nd, …) and ends the game once every player has either finished or been eliminated.

Parameters:
- N_PLAYERS, 4, number of player lanes (2..8).
- COUNTDOWN, 4, cycles spent in COUNTDOWN before first green (1..255).
- GREEN_MIN, 8, minimum green-phase length in cycles (1..240).
- GREEN_RAND_BITS, 3, number of LFSR bits added to GREEN_MIN (0..4).
- RED_CYCLES, 6, red-phase length in cycles (1..255).
- LFSR_SEED, 8'hA5, LFSR reset value (must be nonzero).

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- start  in  1  game start request, sampled on clk
- player_finish  in  N_PLAYERS  level; player reached max_steps with a winning status
- player_out  in  N_PLAYERS  level; player clicked during red (eliminated)
- enable  out  1  game active; gates player logic
- red  out  1  1 = red light, 0 = green
- state  out  3  0 IDLE, 1 COUNTDOWN, 2 GREEN, 3 RED, 4 DONE
- countdown  out  8  remaining phase timer value
- place_valid  out  1  one-cycle strobe: a place was assigned
- place_player  out  clog2(N_PLAYERS)  index of the player that was placed
- place_rank  out  clog2(N_PLAYERS+1)  place assigned, 1-based
- done  out  1  high in DONE

Behaviour:
- Interface decision: reset rst, asynchronous, active-high; clock clk. Everything else is synchronous to posedge clk.

Reset:
- state=IDLE, enable=0, red=1, countdown=0, place_valid=0, place_player=0, place_rank=0, done=0.
- Internal: finished_mask=0, out_mask=0, next_rank=1, lfsr=LFSR_SEED.
- rst mid-game aborts immediately to these values.

LFSR:
- 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1.
- Shifts every cycle when not in reset, in all states.

Timer:
- 8 bits, decrements by 1 per cycle in COUNTDOWN, GREEN and RED.
- Drives the `countdown` output.

FSM:
- IDLE: enable=0, red=1. start=1 -> COUNTDOWN, timer=COUNTDOWN-1.
- COUNTDOWN: enable=0, red=1. When timer==0 -> GREEN, timer=GREEN_MIN-1+lfsr[GREEN_RAND_BITS-1:0] (lfsr value in the transition cycle). A COUNTDOWN of 4 therefore lasts exactly 4 cycles.
- GREEN: enable=1, red=0. When timer==0 -> RED, timer=RED_CYCLES-1.
- RED: enable=1, red=1. Players clicking now get eliminated by their own logic. When timer==0 -> GREEN, with a fresh random reload.
- DONE: enable=0, red=1, done=1, countdown=0. start=1 -> clear both masks, next_rank=1, -> COUNTDOWN.
- start in COUNTDOWN, GREEN or RED is ignored.
- `red` and `enable` are registered and change in the same cycle `state` changes.

Finish arbiter (active in GREEN and RED only):
- cand = player_finish & ~finished_mask & ~out_mask.
- If cand != 0, pick the lowest set index i. That cycle: place_valid=1, place_player=i, place_rank=next_rank; set finished_mask[i]; next_rank += 1.
- Simultaneous finishers are placed one per cycle in ascending index order, with consecutive ranks.
- place_valid is deasserted (0) in cycles with no placement; place_player/place_rank hold their last values.
- Elimination: any player_out bit not in finished_mask sets out_mask in the same cycle; it receives no rank.
- A player already in finished_mask ignores later player_out.
- A player in out_mask is never placed.
- player_finish/player_out asserted in IDLE, COUNTDOWN or DONE are ignored and not latched.

Game end:
- When (finished_mask | out_mask) including this cycle's updates is all ones, the next state is DONE, overriding the timer transition.
- The last place_valid strobe and entry into DONE occur on the same clock edge.
- If all players are eliminated, DONE is entered with no place strobes issued.

Test Plan:
- Reset then start=1 for 1 cycle at edge t: state=1 at t+1 with countdown=3; state=2 (GREEN, enable=1, red=0) at t+5.
- Hold all inputs low: GREEN length within 8..15 cycles; each RED exactly 6 cycles with red=1, enable=1; repeat 3 cycles, with green lengths matching a reference LFSR model seeded 0xA5.
- In GREEN, raise player_finish=4'b0110 in one cycle: place_valid on 2 consecutive cycles with (player 1, rank 1) then (player 2, rank 2).
- player_out=4'b1001 during RED, then player_finish[1] and player_finish[2]: expect ranks 1 and 2 only, then DONE with done=1, enable=0 on the same edge as the second strobe.
- rst asserted mid-GREEN with a mask partially set: all outputs return to reset values immediately, without waiting for clk; a new start yields rank 1 again.
- In DONE, player_finish toggling produces no strobes; start=1 -> COUNTDOWN with both masks cleared.
